uart_tx_frame: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter: configurable data width, parity mode, stop-bit count and baud divisor, with a valid/ready byte-input handshake and gapless back-to-back frames. Sits between a byte source (FIFO or register-file write port) and the serial TX pin. Contains its own bit-period counter, which restarts at every frame start so each bit lasts exactly CLK_DIV cycles. No external clock enable.

---
 rtl/uart_tx_frame_if.sv | 11 +
 rtl/uart_tx_frame.sv | 108 ++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte-source handshake into the UART transmitter: valid/ready with the word to send.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity,
// STOP_BITS stop bits, CLK_DIV clocks per bit, gapless chaining on the last stop cycle.
module uart_tx_frame #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_frame_if.slave   bus,
  output logic             tx,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DW-1:0]        dcnt, dcnt_n;
  logic                 scnt, scnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 tx_n, bit_end, last_stop, ready, accept;

  assign bit_end     = (bcnt == B_LAST);
  assign last_stop   = (state == STOP) && bit_end && (scnt == S_LAST);
  // Ready in the final stop cycle lets the next start bit follow with no mark gap.
  assign ready       = !reset && ((state == IDLE) || last_stop);
  assign accept      = bus.s_valid && ready;
  assign bus.s_ready = ready;
  assign busy        = (state != IDLE);

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    dcnt_n  = dcnt;
    scnt_n  = scnt;
    shift_n = shift;
    par_n   = par;
    if (state != IDLE) bcnt_n = bit_end ? '0 : bcnt + 1'b1;
    unique case (state)
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = {1'b0, shift[DATA_BITS-1:1]};
        if (dcnt == D_LAST) begin
          dcnt_n  = '0;
          state_n = (PARITY != 0) ? PAR : STOP;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      PAR: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        if (scnt == S_LAST) begin
          scnt_n  = 1'b0;
          state_n = IDLE;
        end else begin
          scnt_n = 1'b1;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_n = START;
      bcnt_n  = '0;
      dcnt_n  = '0;
      scnt_n  = 1'b0;
      shift_n = bus.s_data;
      par_n   = (PARITY == 1) ? ~^bus.s_data : ^bus.s_data;
    end
    // tx follows the next state so the line changes on the same edge as the state.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
      dcnt  <= '0;
      scnt  <= 1'b0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      dcnt  <= dcnt_n;
      scnt  <= scnt_n;
      shift <= shift_n;
      par   <= par_n;
      tx    <= tx_n;
      done  <= last_stop;
    end
  end
endmodule
